ex_stage: RTL
=============

# ex_stage

Pipelined execute stage that sits between operand fetch (register file read) and the memory/writeback stage, wrapping the existing combinational `ALU` behind a valid/ready handshake. It accepts one operation bundle per cycle, evaluates it through `ALU`, and registers the result, Zero, and destination information into a 2-entry output buffer so that downstream backpressure never drops or reorders an operation.

## Interface
- `WIDTH`, default 64: operand/result width.
- `RADDR`, default 5: destination register index width.
- `CLK` input 1: single clock, rising edge.
- `resetl` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream bundle present.
- `in_ready` output 1: stage can accept this cycle.
- `in_a` input WIDTH: operand A, drives ALU BusA.
- `in_b` input WIDTH: operand B, drives ALU BusB; shift amount for LSL/LSR.
- `in_ctrl` input 4: ALUCtrl code.
- `in_rd` input RADDR: destination register.
- `in_wr` input 1: register-write enable carried through.
- `in_setflags` input 1: flag-setting op; ignored without `EX_FLAGS_EN`.
- `out_valid` output 1: result bundle present.
- `out_ready` input 1: downstream accepts.
- `out_result` output WIDTH: registered BusW.
- `out_zero` output 1: registered Zero.
- `out_rd` output RADDR, `out_wr` output 1: carried through.
- `out_illegal` output 1: `in_ctrl` was an undefined code.
- `out_flags` output 4: NZCV after this op; constant 0 without `EX_FLAGS_EN`.
- `out_count` output 32: number of completed output handshakes.

## Operation
- Legal codes: 0 AND, 1 OR, 2 ADD, 3 LSL, 4 LSR, 6 SUB, 7 PASSB. Codes 5, 8–F are illegal. For an illegal code, the stored result is 0, Zero is 1, and `out_illegal` is 1; the bundle still flows.
- Shifts use the full `in_b` value. An amount ≥ WIDTH yields 0.
- ADD and SUB wrap modulo 2^WIDTH. Zero is 1 exactly when the result is 0.
- Buffer FSM states:
  - EMPTY: no entries.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Accept = `in_valid & in_ready`. Consume = `out_valid & out_ready`.
- Transitions:
  - EMPTY, accept → ONE (main loaded).
  - ONE, accept & consume → ONE (main reloaded).
  - ONE, accept & !consume → TWO (skid loaded).
  - ONE, consume only → EMPTY.
  - TWO, consume → ONE (skid moves to main).
  - TWO never accepts.
- `in_ready` = state != TWO, driven from the registered state.
- `out_valid` = state != EMPTY. All out_* fields come from the main register.
- Order is strictly preserved.
- `out_count` increments on each consume and wraps from 2^32−1 to 0.

## Timing
- Latency is 1 cycle: a bundle accepted at edge k is visible on out_* after edge k. It is consumable in the cycle following acceptance at the earliest.
- Throughput is 1 bundle/cycle while `out_ready` stays high.
- Output data is stable while `out_valid & !out_ready`.
- Reset (asynchronous, `resetl` = 0) applies immediately, including mid-transfer. On reset:
  - State goes to EMPTY; buffered entries are discarded.
  - `out_valid` = 0, `in_ready` = 1.
  - All out_* data = 0, `out_count` = 0, flags = 0.
- After reset release, the first accept is possible on the first edge.

## Configuration
- Macro: `EX_FLAGS_EN`.
- With `EX_FLAGS_EN` defined, an NZCV register is updated at accept time, in program order, when `in_setflags` = 1:
  - ADD: N = result MSB, Z = result==0, C = carry out, V = signed overflow.
  - SUB: C = no borrow (a ≥ b unsigned), V = signed overflow.
  - AND: N and Z from the result; C = V = 0.
  - Other codes: flags unchanged.
  - The post-update NZCV is stored with the bundle and presented on `out_flags`.
- Without `EX_FLAGS_EN`: no flag register exists, `in_setflags` is ignored, and `out_flags` is tied to 0.

## Structure
- Shared package `ex_pkg` holds:
  - The ALUCtrl constants (`ALU_AND`=4'h0, `ALU_OR`=4'h1, `ALU_ADD`=4'h2, `ALU_LSL`=4'h3, `ALU_LSR`=4'h4, `ALU_SUB`=4'h6, `ALU_PASSB`=4'h7).
  - The FSM state encoding.
  - The NZCV bit positions.
- Sub-module: the existing `ALU`, instantiated once. Flag computation and the illegal-code override stay in `ex_stage`.

## Test plan
- ADD: a=64'h1234, b=64'hABCD0000, ctrl 2, `out_ready`=1 → next cycle `out_valid`=1, result 64'hABCD1234, zero 0, `out_count`=1.
- Backpressure: `out_ready`=0 with three back-to-back bundles (OR, LSL by 1 of 64'h7F0C4B3F, PASSB) → first two accepted and `in_ready`=0 after the second. Raise `out_ready` → results drain in order (64'h7F0E7B3F for OR with b=64'h5A0E7A39, then 64'hFE18967E), and the third is then accepted.
- SUB: a=b=64'h7F0C4B3F, setflags, `EX_FLAGS_EN` → result 0, zero 1, NZCV=4'b0110.
- ADDS: a=64'h7FFFFFFFFFFFFFFF, b=1, `EX_FLAGS_EN` → result 64'h8000000000000000, NZCV=4'b1001.
- Corner codes:
  - ctrl 4'h5 → result 0, zero 1, `out_illegal` 1.
  - LSR by 64 → result 0, zero 1.
- Reset: assert `resetl`=0 mid-cycle while in TWO → `out_valid`=0 and `in_ready`=1 without waiting for a clock edge, `out_count`=0, and no stale bundle appears after release.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU control codes, buffer state
// encoding and NZCV bit positions.
package ex_pkg;

  localparam logic [3:0] ALU_AND   = 4'h0;
  localparam logic [3:0] ALU_OR    = 4'h1;
  localparam logic [3:0] ALU_ADD   = 4'h2;
  localparam logic [3:0] ALU_LSL   = 4'h3;
  localparam logic [3:0] ALU_LSR   = 4'h4;
  localparam logic [3:0] ALU_SUB   = 4'h6;
  localparam logic [3:0] ALU_PASSB = 4'h7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_LSL, ALU_LSR, ALU_SUB, ALU_PASSB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ALU.sv
// Combinational ALU; undefined control codes produce 0, which the execute
// stage overrides explicitly anyway.
module ALU
  import ex_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero
);

  // Logical shifts by the full BusB value naturally yield 0 past WIDTH-1.
  always_comb begin
    BusW = '0;
    case (ALUCtrl)
      ALU_AND:   BusW = BusA & BusB;
      ALU_OR:    BusW = BusA | BusB;
      ALU_ADD:   BusW = BusA + BusB;
      ALU_LSL:   BusW = BusA << BusB;
      ALU_LSR:   BusW = BusA >> BusB;
      ALU_SUB:   BusW = BusA - BusB;
      ALU_PASSB: BusW = BusB;
      default:   BusW = '0;
    endcase
  end

  assign Zero = (BusW == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU behind a valid/ready handshake with a 2-entry output
// buffer. Define EX_FLAGS_EN to add the NZCV flag register.
//
// state    | meaning
// ST_EMPTY | no entries buffered
// ST_ONE   | main register valid
// ST_TWO   | main and skid registers valid, input stalled
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RADDR = 5
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctrl,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_wr,
  input  logic             in_setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [RADDR-1:0] out_rd,
  output logic             out_wr,
  output logic             out_illegal,
  output logic [3:0]       out_flags,
  output logic [31:0]      out_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [RADDR-1:0] rd;
    logic             wr;
    logic             illegal;
    logic [3:0]       flags;
  } entry_t;

  logic [1:0]       state;
  entry_t           main_q, skid_q, new_entry;
  logic [WIDTH-1:0] alu_w;
  logic             alu_zero, legal, accept, consume;
  logic [3:0]       entry_flags;

  ALU #(.WIDTH(WIDTH)) u_alu (
    .BusA    (in_a),
    .BusB    (in_b),
    .ALUCtrl (in_ctrl),
    .BusW    (alu_w),
    .Zero    (alu_zero)
  );

  assign legal   = ctrl_legal(in_ctrl);
  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

`ifdef EX_FLAGS_EN
  logic [3:0] nzcv_q, nzcv_next;

  // Carry out of an add is visible as the wrapped sum being below an operand.
  always_comb begin
    nzcv_next = nzcv_q;
    if (in_setflags) begin
      case (in_ctrl)
        ALU_ADD: begin
          nzcv_next[FLAG_N] = alu_w[WIDTH-1];
          nzcv_next[FLAG_Z] = alu_zero;
          nzcv_next[FLAG_C] = (alu_w < in_a);
          nzcv_next[FLAG_V] = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                              (alu_w[WIDTH-1] != in_a[WIDTH-1]);
        end
        ALU_SUB: begin
          nzcv_next[FLAG_N] = alu_w[WIDTH-1];
          nzcv_next[FLAG_Z] = alu_zero;
          nzcv_next[FLAG_C] = (in_a >= in_b);
          nzcv_next[FLAG_V] = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                              (alu_w[WIDTH-1] != in_a[WIDTH-1]);
        end
        ALU_AND: begin
          nzcv_next[FLAG_N] = alu_w[WIDTH-1];
          nzcv_next[FLAG_Z] = alu_zero;
          nzcv_next[FLAG_C] = 1'b0;
          nzcv_next[FLAG_V] = 1'b0;
        end
        default: nzcv_next = nzcv_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl)     nzcv_q <= 4'b0;
    else if (accept) nzcv_q <= nzcv_next;
  end

  assign entry_flags = nzcv_next;
`else
  logic unused_setflags;
  assign unused_setflags = in_setflags;
  assign entry_flags     = 4'b0;
`endif

  always_comb begin
    new_entry.result  = legal ? alu_w : '0;
    new_entry.zero    = legal ? alu_zero : 1'b1;
    new_entry.rd      = in_rd;
    new_entry.wr      = in_wr;
    new_entry.illegal = ~legal;
    new_entry.flags   = entry_flags;
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state     <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_count <= '0;
    end else begin
      if (consume) out_count <= out_count + 32'd1;
      case (state)
        ST_EMPTY: if (accept) begin
          main_q <= new_entry;
          state  <= ST_ONE;
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_q <= new_entry;
          end else if (accept) begin
            skid_q <= new_entry;
            state  <= ST_TWO;
          end else if (consume) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: if (consume) begin
          main_q <= skid_q;
          state  <= ST_ONE;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign in_ready    = (state != ST_TWO);
  assign out_valid   = (state != ST_EMPTY);
  assign out_result  = main_q.result;
  assign out_zero    = main_q.zero;
  assign out_rd      = main_q.rd;
  assign out_wr      = main_q.wr;
  assign out_illegal = main_q.illegal;
  assign out_flags   = main_q.flags;

endmodule
